// File: rtl/bcd_addsub_serial.sv
//------------------------------------------------------------------------------
// bcd_addsub_serial : digit-serial packed-BCD adder/subtractor, LSD first
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  carry_borrow,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_mode;
  logic            r_cin;
  logic [IW-1:0]   r_idx;

  logic            w_bad;
  logic [IW+1:0]   w_shamt;
  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [3:0]      w_ad;
  logic [3:0]      w_bd;
  logic [4:0]      w_sum;
  logic [4:0]      w_bc;
  logic [4:0]      w_dig5;
  logic [3:0]      w_digit;
  logic            w_cout;
  logic            w_last;
  logic [W-1:0]    w_mask;
  logic [W-1:0]    w_ins;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
        w_bad = 1'b1;
      end
    end
  end

  // Current digit is selected by shifting the operand down, not by a variable part-select.
  assign w_shamt = {r_idx, 2'b00};
  assign w_a_sh  = r_a >> w_shamt;
  assign w_b_sh  = r_b >> w_shamt;
  assign w_ad    = w_a_sh[3:0];
  assign w_bd    = w_b_sh[3:0];
  assign w_sum   = {1'b0, w_ad} + {1'b0, w_bd} + {4'b0000, r_cin};
  assign w_bc    = {1'b0, w_bd} + {4'b0000, r_cin};

  always_comb begin
    w_dig5 = 5'd0;
    w_cout = 1'b0;
    if (!r_mode) begin
      if (w_sum > 5'd9) begin
        w_dig5 = w_sum - 5'd10;
        w_cout = 1'b1;
      end else begin
        w_dig5 = w_sum;
      end
    end else begin
      if ({1'b0, w_ad} < w_bc) begin
        w_dig5 = {1'b0, w_ad} + 5'd10 - w_bc;
        w_cout = 1'b1;
      end else begin
        w_dig5 = {1'b0, w_ad} - w_bc;
      end
    end
  end

  assign w_digit = w_dig5[3:0];
  assign w_last  = (r_idx == IW'(DIGITS - 1));
  assign w_mask  = W'(4'hF) << w_shamt;
  assign w_ins   = W'(w_digit) << w_shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_mode       <= 1'b0;
      r_cin        <= 1'b0;
      r_idx        <= '0;
      result       <= '0;
      carry_borrow <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a          <= a;
            r_b          <= b;
            r_mode       <= mode;
            r_cin        <= 1'b0;
            r_idx        <= '0;
            result       <= '0;
            carry_borrow <= 1'b0;
            err          <= w_bad;
          end
        end
        S_RUN: begin
          result <= (result & ~w_mask) | w_ins;
          r_cin  <= w_cout;
          r_idx  <= r_idx + IW'(1);
          if (w_last) begin
            carry_borrow <= w_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_addsub_serial.sv
//------------------------------------------------------------------------------
// tb_bcd_addsub_serial : table, hand-written and random checks against a decimal model
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_addsub_serial;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry_borrow;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry_borrow (carry_borrow),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] er;
    logic        ecb;
    logic        eerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Decimal reference: convert to integers, do the arithmetic, wrap mod 10^4.
  function automatic void model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] r, output logic cb, output logic e);
    int xa, ya, s;
    logic [15:0] xv, yv;
    xv = x; yv = y;
    xa = 0; ya = 0; e = 1'b0; r = '0; cb = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (xv[4*i +: 4] > 4'd9 || yv[4*i +: 4] > 4'd9) e = 1'b1;
      xa = xa * 10 + int'(xv[4*i +: 4]);
      ya = ya * 10 + int'(yv[4*i +: 4]);
    end
    if (e) return;
    s  = m ? (xa - ya) : (xa + ya);
    cb = (s < 0) || (s >= 10000);
    if (s < 0) s += 10000;
    s = s % 10000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
  endfunction

  task automatic exec_check(input string nm, input logic m, input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] er, input logic ecb, input logic eerr);
    int lat;
    bit saw_busy;
    @(negedge clk);
    start = 1'b1; mode = m; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; saw_busy = 0;
    while (!done && lat < 20) begin
      if (busy) saw_busy = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, eerr ? 0 : DIGITS);
    chk({nm, " result"}, result, er);
    chk({nm, " carry_borrow"}, carry_borrow, ecb);
    chk({nm, " err"}, err, eerr);
    if (eerr) chk({nm, " busy_on_err"}, saw_busy, 0);
    a = 16'($urandom); b = 16'($urandom); mode = ~m;
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, done, 1'b0);
    chk({nm, " result_held"}, {err, carry_borrow, result}, {eerr, ecb, er});
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] ra, rb, er;
    logic ecb, eerr, rm;
    int pulses, lat;

    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;

    vecs[0] = '{1'b0, 16'h0456, 16'h0789, 16'h1245, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h5000, 16'h4999, 16'h0001, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, carry_borrow, err, result}, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      exec_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].va, vecs[i].vb,
                 vecs[i].er, vecs[i].ecb, vecs[i].eerr);
    end

    // start held through RUN, operands changed mid-run
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h0456; b = 16'h0789;
    pulses = 0; lat = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (lat < 0) lat = c;
        start = 1'b0;
      end
      if (c == 2) begin a = 16'h9999; b = 16'h9999; end
    end
    start = 1'b0;
    chk("held_start pulses", pulses, 1);
    chk("held_start latency", lat, DIGITS);
    chk("held_start result", {carry_borrow, result}, {1'b0, 16'h1245});

    // reset during RUN cycle 2
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 16'h0456; b = 16'h0789;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_reset outputs", {busy, done, carry_borrow, err, result}, '0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("after_reset no_done", pulses, 0);
    exec_check("post_reset", 1'b0, 16'h0123, 16'h0456, 16'h0579, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      rm = 1'($urandom_range(0, 1));
      model(rm, ra, rb, er, ecb, eerr);
      exec_check($sformatf("rand%0d", n), rm, ra, rb, er, ecb, eerr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
